// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_pkg: shared types and defaults for the frame-buffer BRAM arbiter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } fb_state_e;

  localparam int unsigned c_DATA_WIDTH   = 12;
  localparam int unsigned c_FRAME_PIXELS = 307200;
  localparam int unsigned c_ADDR_WIDTH   = 19;

  // Smallest display-FIFO almost-full offset that absorbs every in-flight read.
  function automatic int unsigned fb_min_af_offset(input int unsigned rd_latency);
    return rd_latency + 32'd2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_rd_pipe: read-valid delay line matching BRAM latency, plus the FIFO     |
// | output data register. i_clr discards everything in flight.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fb_rd_pipe
  import fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic                  i_issue,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_fifo_wr,
  output logic [DATA_WIDTH-1:0] o_fifo_wdata,
  output logic                  o_empty
);

  logic [RD_LATENCY-1:0] r_vld;
  logic                  r_fifo_wr;
  logic [DATA_WIDTH-1:0] r_fifo_wdata;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_vld        <= '0;
      r_fifo_wr    <= 1'b0;
      r_fifo_wdata <= '0;
    end else begin
      // Shift toward the MSB; the MSB lines up with valid BRAM read data.
      r_vld     <= RD_LATENCY'({r_vld, i_issue});
      r_fifo_wr <= r_vld[RD_LATENCY-1];
      if (r_vld[RD_LATENCY-1]) begin
        r_fifo_wdata <= i_rdata;
      end
    end
  end

  assign o_fifo_wr    = r_fifo_wr;
  assign o_fifo_wdata = r_fifo_wdata;
  assign o_empty      = ~|r_vld;

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_arbiter: shares a single-port frame-buffer BRAM between the pixel       |
// | writer (always wins) and the frame prefetch reader (fills idle cycles).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = c_DATA_WIDTH,
  parameter int unsigned FRAME_PIXELS = c_FRAME_PIXELS,
  parameter int unsigned ADDR_WIDTH   = c_ADDR_WIDTH,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_req,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_fifo_wr,
  output logic [DATA_WIDTH-1:0] o_fifo_wdata,
  input  logic                  i_fifo_almostfull,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_wr_wrap,
  output logic                  o_req_overrun
);

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   c_FRAME_CNT = (ADDR_WIDTH + 1)'(FRAME_PIXELS);

  fb_state_e             r_state;
  fb_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH:0]   r_issued;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_wr_wrap;
  logic                  r_req_overrun;
  logic                  w_wr;
  logic                  w_rd_issue;
  logic                  w_pipe_empty;
  logic                  w_fifo_wr;
  logic                  w_drain_done;

  assign w_wr         = i_wr_valid && !i_rst;
  assign w_drain_done = (r_state == DRAIN) && w_pipe_empty && w_fifo_wr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_req) w_state_nxt = STREAM;
      STREAM:  if (r_issued == c_FRAME_CNT) w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // BRAM port: the writer always takes the cycle, a read only fills a free one.
  always_comb begin
    w_rd_issue  = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = r_rd_addr;
    o_mem_wdata = '0;
    if ((r_state == STREAM) && !i_rst && !i_wr_valid && !i_fifo_almostfull &&
        (r_issued < c_FRAME_CNT)) begin
      w_rd_issue = 1'b1;
    end
    if (w_wr) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = r_wr_addr;
      o_mem_wdata = i_wr_data;
    end else if (w_rd_issue) begin
      o_mem_en = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_issued      <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_wr_wrap     <= 1'b0;
      r_req_overrun <= 1'b0;
    end else begin
      r_busy        <= (w_state_nxt != IDLE);
      r_frame_done  <= w_drain_done;
      r_req_overrun <= i_req && (r_state != IDLE);
      r_wr_wrap     <= w_wr && (r_wr_addr == c_LAST_ADDR);
      if (w_wr) begin
        r_wr_addr <= (r_wr_addr == c_LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
      end
      if ((r_state == IDLE) && i_req) begin
        r_rd_addr <= '0;
        r_issued  <= '0;
      end else if (w_rd_issue) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        r_issued  <= r_issued + 1'b1;
      end
    end
  end

  fb_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .i_clk        (i_clk),
    .i_clr        (i_rst),
    .i_issue      (w_rd_issue),
    .i_rdata      (i_mem_rdata),
    .o_fifo_wr    (w_fifo_wr),
    .o_fifo_wdata (o_fifo_wdata),
    .o_empty      (w_pipe_empty)
  );

  assign o_fifo_wr     = w_fifo_wr;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_wr_wrap     = r_wr_wrap;
  assign o_req_overrun = r_req_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fb_arbiter: table vectors, directed corner sequences and random traffic |
// | checked cycle by cycle against a transaction-level model. Revision: 1.0    |
// +----------------------------------------------------------------------------+
module tb_fb_arbiter;

  localparam int N   = 16;
  localparam int LAT = 2;
  localparam int DW  = 12;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          req = 1'b0;
  logic          af = 1'b0;
  logic          pre = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          mem_en, mem_we, fifo_wr, busy, frame_done, wr_wrap, req_overrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, fifo_wdata;

  fb_arbiter #(.DATA_WIDTH(DW), .FRAME_PIXELS(N), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .i_wr_data(wr_data), .i_req(req),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_fifo_wr(fifo_wr), .o_fifo_wdata(fifo_wdata),
    .i_fifo_almostfull(af), .o_busy(busy), .o_frame_done(frame_done),
    .o_wr_wrap(wr_wrap), .o_req_overrun(req_overrun));

  always #5 clk = ~clk;

  // Two-stage registered BRAM model
  logic [DW-1:0] bram [N];
  logic [DW-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < N; i++) bram[i] <= DW'(i * 3);
    end else if (mem_en && mem_we) begin
      bram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) p1 <= bram[mem_addr];
    p2 <= p1;
  end
  assign mem_rdata = p2;

  // Transaction-level reference model
  typedef struct { int due; logic [DW-1:0] data; } rd_t;
  rd_t           m_q[$];
  logic [DW-1:0] m_mem [N];
  int m_wr_addr = 0, m_rd_addr = 0, m_issued = 0, cyc = 0;
  bit m_busy = 0, m_wrap = 0, m_done = 0, m_ovr = 0;

  int rd_log[$], rd_cyc[$], ff_log[$], ff_cyc[$], done_cyc[$];
  int n_wr = 0;
  int s_en, s_addr, s_wrap, s_ovr, s_busy;
  int n_vec = 0, n_err = 0;

  typedef struct { logic wr_valid; logic [DW-1:0] wdata; logic [AW-1:0] exp_addr; logic exp_wrap; } vec_t;
  vec_t tbl[22];

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic step();
    bit w, r, fw;
    rd_t e;
    @(negedge clk);
    w  = !rst && wr_valid;
    r  = !rst && !wr_valid && m_busy && !af && (m_issued < N);
    fw = (m_q.size() > 0) && (m_q[0].due == cyc);
    chk("mem_en", int'(mem_en), int'(w || r));
    chk("mem_we", int'(mem_we), int'(w));
    if (w) begin
      chk("wr_addr", int'(mem_addr), m_wr_addr);
      chk("wr_data", int'(mem_wdata), int'(wr_data));
    end
    if (r) chk("rd_addr", int'(mem_addr), m_rd_addr % N);
    chk("fifo_wr", int'(fifo_wr), int'(fw));
    if (fw) chk("fifo_data", int'(fifo_wdata), int'(m_q[0].data));
    chk("busy", int'(busy), int'(m_busy));
    chk("frame_done", int'(frame_done), int'(m_done));
    chk("wr_wrap", int'(wr_wrap), int'(m_wrap));
    chk("overrun", int'(req_overrun), int'(m_ovr));
    if (mem_en && !mem_we) begin rd_log.push_back(int'(mem_addr)); rd_cyc.push_back(cyc); end
    if (mem_en && mem_we) n_wr++;
    if (fifo_wr) begin ff_log.push_back(int'(fifo_wdata)); ff_cyc.push_back(cyc); end
    if (frame_done) done_cyc.push_back(cyc);
    s_en = int'(mem_en); s_addr = int'(mem_addr); s_wrap = int'(wr_wrap);
    s_ovr = int'(req_overrun); s_busy = int'(busy);
    if (fw) void'(m_q.pop_front());
    if (rst) begin
      m_q.delete();
      m_wr_addr = 0; m_rd_addr = 0; m_issued = 0;
      m_busy = 0; m_wrap = 0; m_done = 0; m_ovr = 0;
    end else begin
      m_wrap = w && (m_wr_addr == N - 1);
      m_done = m_busy && fw && (m_q.size() == 0) && (m_issued == N);
      m_ovr  = req && m_busy;
      if (w) begin
        m_mem[m_wr_addr] = wr_data;
        m_wr_addr = (m_wr_addr + 1) % N;
      end
      if (r) begin
        e.due = cyc + LAT + 1; e.data = m_mem[m_rd_addr % N];
        m_q.push_back(e);
        m_rd_addr++; m_issued++;
      end
      if (!m_busy && req) begin m_busy = 1; m_rd_addr = 0; m_issued = 0; end
      else if (m_done) m_busy = 0;
    end
    if (pre) for (int i = 0; i < N; i++) m_mem[i] = DW'(i * 3);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_logs();
    rd_log.delete(); rd_cyc.delete(); ff_log.delete(); ff_cyc.delete(); done_cyc.delete();
  endtask

  task automatic wait_done(int cap);
    int k = 0;
    while (done_cyc.size() == 0 && k < cap) begin step(); k++; end
    chk("frame_done_seen", done_cyc.size(), 1);
  endtask

  task automatic wait_rd(int n, int cap);
    int k = 0;
    while (rd_log.size() < n && k < cap) begin step(); k++; end
    chk("reads_issued", rd_log.size(), n);
  endtask

  task automatic start_frame();
    clr_logs();
    req = 1'b1; step(); req = 1'b0;
  endtask

  task automatic chk_order(string nm, int n);
    chk({nm, "_count"}, rd_log.size(), n);
    for (int i = 0; i < rd_log.size(); i++) chk({nm, "_addr"}, rd_log[i], i);
  endtask

  initial begin
    int nw, nff;
    for (int i = 0; i < 22; i++) begin
      tbl[i].wr_valid = (i < 20);
      tbl[i].wdata    = DW'(i + 1);
      tbl[i].exp_addr = AW'(i % 16);
      tbl[i].exp_wrap = (i == 16);
    end
    @(posedge clk); #1;

    // Reset held for 3 cycles with a toggling writer
    for (int i = 0; i < 3; i++) begin
      wr_valid = (i % 2 == 0); wr_data = DW'(12'h0a0 + i);
      step();
      chk("rst_mem_en", s_en, 0);
    end
    rst = 1'b0;

    // Write wrap table
    for (int i = 0; i < 22; i++) begin
      wr_valid = tbl[i].wr_valid; wr_data = tbl[i].wdata;
      step();
      chk("tbl_en", s_en, int'(tbl[i].wr_valid));
      if (tbl[i].wr_valid) chk("tbl_addr", s_addr, int'(tbl[i].exp_addr));
      chk("tbl_wrap", s_wrap, int'(tbl[i].exp_wrap));
    end
    wr_valid = 1'b0;
    pre = 1'b1; step(); pre = 1'b0;

    // Clean frame read
    start_frame();
    wait_done(80);
    chk_order("rf", N);
    for (int i = 1; i < rd_cyc.size(); i++) chk("rf_consec", rd_cyc[i] - rd_cyc[0], i);
    chk("rf_nff", ff_log.size(), N);
    for (int i = 0; i < ff_log.size(); i++) chk("rf_data", ff_log[i], 3 * i);
    if (ff_cyc.size() > 0 && rd_cyc.size() > 0) chk("rf_latency", ff_cyc[0] - rd_cyc[0], LAT + 1);
    if (ff_cyc.size() > 0 && done_cyc.size() > 0) chk("rf_done_cyc", done_cyc[0], ff_cyc[$] + 1);
    step();
    chk("rf_idle", s_busy, 0);

    // Writer collision every 4th cycle
    start_frame();
    nw = n_wr;
    begin
      int k = 0, exp_w = 0;
      while (done_cyc.size() == 0 && k < 200) begin
        wr_valid = (k % 4 == 0); wr_data = DW'($urandom);
        if (wr_valid) exp_w++;
        step(); k++;
      end
      wr_valid = 1'b0;
      chk("col_done", done_cyc.size(), 1);
      chk("col_writes", n_wr - nw, exp_w);
    end
    chk_order("col", N);

    // Almost-full backpressure after 5 issues
    start_frame();
    wait_rd(5, 50);
    af = 1'b1; steps(10);
    chk("bp_no_issue", rd_log.size(), 5);
    chk("bp_drain", ff_log.size(), 5);
    af = 1'b0;
    wait_done(100);
    chk_order("bp", N);

    // Overrun mid-stream, then reset with two reads in flight
    start_frame();
    wait_rd(3, 50);
    req = 1'b1; step(); req = 1'b0;
    step();
    chk("ovr_pulse", s_ovr, 1);
    wait_rd(8, 50);
    rst = 1'b1; step(); rst = 1'b0;
    nff = ff_log.size();
    steps(8);
    chk("rst_no_fifo_wr", ff_log.size(), nff);
    chk("rst_idle", s_busy, 0);
    chk_order("ovr", 8);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      wr_valid = ($urandom_range(0, 4) == 0);
      wr_data  = DW'($urandom);
      req      = ($urandom_range(0, 39) == 0);
      af       = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
